// File: rtl/clock_pkg.sv
// Shared state encodings, time-field limits and wrap helper for the clock controller.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    localparam logic [5:0] HOUR_MAX = 6'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] SEC_MAX  = 6'd59;

    function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max);
        return (val >= max) ? 6'd0 : val + 6'd1;
    endfunction

endpackage

// File: rtl/debouncer.sv
// Button conditioner: 2-flop synchronizer, stability down-counter and
// single-cycle pulse on each accepted rising level.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    // The counter reloads whenever the synchronized sample agrees with the
    // accepted level, so only an unbroken run of differing samples reaches zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= CNT_LOAD;
            press_o <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            press_o <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= CNT_LOAD;
            end else if (cnt_q == '0) begin
                level_q <= sync_q[1];
                cnt_q   <= CNT_LOAD;
                press_o <= sync_q[1];
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_ctrl.sv
// 24-hour clock with button-driven hour/minute setting and edit-field blink.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | time advances once per second tick, inc ignored
// SET_HOUR | chain frozen, inc steps hours (23 -> 0), field blinks
// SET_MIN  | chain frozen, inc steps minutes (59 -> 0), field blinks;
//          | leaving clears seconds and prescaler
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    output logic [5:0] hour_o,
    output logic [5:0] minute_o,
    output logic [5:0] second_o,
    output logic [1:0] mode_o,
    output logic       blink_o
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX   = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] BLINK_START = PW'(CLK_HZ / 2);

    logic          mode_press;
    logic          inc_press;
    logic          tick;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_nxt;
    state_t        state_q;
    state_t        state_nxt;
    logic [5:0]    hour_q;
    logic [5:0]    min_q;
    logic [5:0]    sec_q;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_mode_i),
        .press_o (mode_press)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_inc_i),
        .press_o (inc_press)
    );

    assign tick = (presc_q == PRESC_MAX);

    always_comb begin
        state_nxt = state_q;
        presc_nxt = tick ? '0 : presc_q + 1'b1;
        case (state_q)
            RUN: begin
                if (mode_press) state_nxt = SET_HOUR;
            end
            SET_HOUR: begin
                if (mode_press) state_nxt = SET_MIN;
            end
            SET_MIN: begin
                if (mode_press) begin
                    state_nxt = RUN;
                    presc_nxt = '0;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Blink is derived from next-cycle state/prescaler so the registered
    // output lines up with the prescaler value it describes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            presc_q <= '0;
            hour_q  <= 6'd0;
            min_q   <= 6'd0;
            sec_q   <= 6'd0;
            blink_o <= 1'b0;
        end else begin
            state_q <= state_nxt;
            presc_q <= presc_nxt;
            blink_o <= (state_nxt != RUN) && (presc_nxt >= BLINK_START);
            case (state_q)
                RUN: begin
                    if (tick) begin
                        sec_q <= wrap_inc(sec_q, SEC_MAX);
                        if (sec_q == SEC_MAX) begin
                            min_q <= wrap_inc(min_q, MIN_MAX);
                            if (min_q == MIN_MAX) hour_q <= wrap_inc(hour_q, HOUR_MAX);
                        end
                    end
                end
                SET_HOUR: begin
                    if (inc_press && !mode_press) hour_q <= wrap_inc(hour_q, HOUR_MAX);
                end
                SET_MIN: begin
                    if (mode_press) sec_q <= 6'd0;
                    else if (inc_press) min_q <= wrap_inc(min_q, MIN_MAX);
                end
                default: ;
            endcase
        end
    end

    assign hour_o   = hour_q;
    assign minute_o = min_q;
    assign second_o = sec_q;
    assign mode_o   = state_q;

endmodule
